// File: rtl/mac_dot_engine.sv
// mac_dot_engine: pipelined TAPS-lane dot product with frame accumulation.
// Ports: clk, rst (async active-low), in_* beat, a_vec/x_vec, out_*, busy.
module mac_dot_engine #(
    parameter int TAPS = 9,
    parameter int DW   = 8,
    parameter int ACCW = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic                 in_signed,
    input  logic [TAPS*DW-1:0]   a_vec,
    input  logic [TAPS*DW-1:0]   x_vec,
    output logic                 out_valid,
    output logic [ACCW-1:0]      out_sum,
    output logic                 out_ovf,
    output logic                 busy
);

    localparam int PW = 2 * DW;

    function automatic logic [PW-1:0] mul(
        input logic [DW-1:0] a,
        input logic [DW-1:0] x,
        input logic          s
    );
        logic signed [PW-1:0] sp;
        logic [PW-1:0]        up;
        sp = $signed(a) * $signed(x);
        up = {{DW{1'b0}}, a} * {{DW{1'b0}}, x};
        return s ? sp : up;
    endfunction

    function automatic logic [ACCW:0] ext(
        input logic [PW-1:0] p,
        input logic          s
    );
        return s ? {{(ACCW+1-PW){p[PW-1]}}, p}
                 : {{(ACCW+1-PW){1'b0}}, p};
    endfunction

    // frame tracker; sign mode is frozen on the first beat
    logic in_frame;
    logic sign_q;
    logic first;
    logic sgn;

    assign first = in_valid & ~in_frame;
    assign sgn   = first ? in_signed : sign_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_frame <= 1'b0;
            sign_q   <= 1'b0;
        end else if (in_valid) begin
            in_frame <= ~in_last;
            if (first)
                sign_q <= in_signed;
        end
    end

    // stage 1: lane multipliers
    logic          s1_valid, s1_first, s1_last, s1_sgn;
    logic [PW-1:0] s1_prod [TAPS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_sgn   <= 1'b0;
            for (int i = 0; i < TAPS; i++)
                s1_prod[i] <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_first <= first;
                s1_last  <= in_last;
                s1_sgn   <= sgn;
                // lane 0 sits in the MSB slice
                for (int i = 0; i < TAPS; i++)
                    s1_prod[i] <= mul(a_vec[(TAPS-1-i)*DW +: DW],
                                      x_vec[(TAPS-1-i)*DW +: DW], sgn);
            end
        end
    end

    // stage 2: adder tree over all lanes
    logic [ACCW:0] tree_c;
    logic          s2_valid, s2_first, s2_last, s2_sgn;
    logic [ACCW:0] s2_tree;

    always_comb begin
        tree_c = '0;
        for (int i = 0; i < TAPS; i++)
            tree_c = tree_c + ext(s1_prod[i], s1_sgn);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_sgn   <= 1'b0;
            s2_tree  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_first <= s1_first;
                s2_last  <= s1_last;
                s2_sgn   <= s1_sgn;
                s2_tree  <= tree_c;
            end
        end
    end

    // stage 3: accumulate with range check in ACCW+1 bits
    logic [ACCW-1:0] acc;
    logic            ovf_q;
    logic [ACCW:0]   acc_ext;
    logic [ACCW:0]   sum_c;
    logic            ovf_c;
    logic            ovf_n;

    always_comb begin
        if (s2_first)
            acc_ext = '0;
        else if (s2_sgn)
            acc_ext = {acc[ACCW-1], acc};
        else
            acc_ext = {1'b0, acc};
        sum_c = acc_ext + s2_tree;
        ovf_c = s2_sgn ? (sum_c[ACCW] ^ sum_c[ACCW-1]) : sum_c[ACCW];
        ovf_n = ovf_c | (~s2_first & ovf_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= s2_valid & s2_last;
            if (s2_valid) begin
                acc   <= sum_c[ACCW-1:0];
                ovf_q <= ovf_n;
                if (s2_last) begin
                    out_sum <= sum_c[ACCW-1:0];
                    out_ovf <= ovf_n;
                end
            end
        end
    end

    assign busy = in_frame | s1_valid | s2_valid;

endmodule

// File: doc/mac_dot_engine.md
# mac_dot_engine

Parametrised pipelined dot-product / multiply-accumulate engine, successor to the fixed 9-tap, 8-bit unsigned MAC in the matrix datapath. Each accepted beat multiplies TAPS pairs of DW-bit operands, reduces them through a registered adder tree, and accumulates across a multi-beat frame so a matrix row longer than TAPS elements can be processed. It supports signed and unsigned operands and reports accumulator overflow. The write-back controller consumes one result per frame.

## Interface
- TAPS, 9, number of multiply lanes per beat (≥2)
- DW, 8, operand width in bits
- ACCW, 24, accumulator and result width; must be ≥ 2*DW + clog2(TAPS)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  beat present; accepted on every rising edge where it is high (no backpressure)
- in_last  in  1  accepted beat is the final beat of its frame
- in_signed  in  1  operands are two's complement; sampled only on the first beat of a frame
- a_vec  in  TAPS*DW  operand A; lane 0 = MSB slice, lane TAPS-1 = LSB slice
- x_vec  in  TAPS*DW  operand X, packed like a_vec
- out_valid  out  1  one-cycle pulse: out_sum/out_ovf hold a new frame result
- out_sum  out  ACCW  frame result, wrap-around modulo 2^ACCW
- out_ovf  out  1  frame result exceeded the ACCW range (sticky within the frame)
- busy  out  1  a frame is open or beats are still in the pipeline

## Operation
- Input frame tracker: the in_frame flag sets on an accepted non-last beat and clears on an accepted last beat. The first beat of a frame is an accepted beat while in_frame=0. The frame's sign mode is latched from in_signed on the first beat and applies to every later beat of that frame.
- A single-beat frame (first and last) is legal.
- Stage 1 (MUL): product[i] = a[i]*x[i], 2*DW bits. Signed mode multiplies the operands as two's complement. Unsigned mode zero-extends them. Stage-1 registers also carry valid, first, last and the sign mode.
- Stage 2 (TREE): sums all TAPS products after extending each to ACCW+1 bits (sign extension in signed mode, zero extension in unsigned mode). The result is registered with its control bits.
- Stage 3 (ACC):
  - On a first beat, acc = tree; otherwise acc = acc + tree.
  - The add is computed in ACCW+1 bits.
  - Overflow means the result leaves [0, 2^ACCW−1] in unsigned mode or [−2^(ACCW−1), 2^(ACCW−1)−1] in signed mode. The ovf flag loads on a first beat and is ORed in on later beats.
  - On a last beat, out_sum is set to acc[ACCW−1:0], out_ovf is set to the frame ovf, and out_valid pulses.
- Bubbles: in_valid low inside a frame is allowed. Bubbles propagate as invalid slots, and the accumulator holds its value.
- out_sum and out_ovf hold their values until the next out_valid.
- busy = in_frame OR any stage valid.

## Timing
- Reset values: out_valid=0, out_sum=0, out_ovf=0, busy=0. All pipeline valids, in_frame, acc and ovf are 0.
- Latency: a last beat accepted at edge T produces out_valid high in the cycle following edge T+2, i.e. 3 cycles after acceptance.
- Throughput is one beat per cycle. Back-to-back frames are supported with no gap: the first beat of frame N+1 may directly follow the last beat of frame N. Every stage correctly loads or accumulates in that case.
- A beat with in_last=1 while in_frame=0 is both first and last.
- Reset mid-frame: all state clears immediately. Partial frames are discarded, no out_valid is produced, and the next accepted beat is a first beat.
- in_signed, a_vec and x_vec are don't-care while in_valid=0.

## Test plan
- Unsigned single beat, TAPS=9, all a=x=255, in_last=1 → 3 cycles later out_valid pulse, out_sum=585225, out_ovf=0.
- Signed single beat, all a=x=0x80 (−128) → out_sum=147456. Next frame: a=0xFF, x=0x01 in all lanes → out_sum=0xFFFFF7 (−9), out_ovf=0.
- 4-beat unsigned frame of all-255 operands, with a one-cycle bubble after beat 2 → a single out_valid with out_sum=2340900. busy stays high from the first beat until out_valid.
- 29-beat unsigned frame of all-255 operands → out_sum=194309 (16971525 mod 2^24), out_ovf=1. The following single-beat frame of all-1 operands gives out_sum=9, out_ovf=0.
- Back-to-back single-beat frames every cycle with lane values 1, 2, 3, … → consecutive out_valid pulses with out_sum=9, 36, 81, …. Sign mode is switched between frames, and the beat after a frame start ignores in_signed.
- Assert rst during beat 2 of a 3-beat frame → all outputs return to 0 and no out_valid is produced. The next 1-beat frame of all-2 operands gives out_sum=36.
